fetch_unit: RTL and testbench

- Fetch stage that produces instrF, pcplus4F and adelF for the F/D pipeline register.
- Owns the PC and drives an SRAM-like instruction-memory interface with separate address and data handshakes.
- Applies branch and exception redirects, even when they arrive while a memory access is in flight.
- Reports inst_stall to the hazard unit while no valid instruction is available for the current PC.

---
 rtl/fetch_unit_pkg.sv | 14 +
 rtl/fetch_redirect_buf.sv | 53 +++++
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] NOP          = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_WAIT    = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_redirect_buf.sv
// Pending-redirect latch: remembers a branch/exception target until the PC next updates.
module fetch_redirect_buf
  import fetch_unit_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        br_valid_i,
  input  logic [31:0] br_target_i,
  input  logic        exc_valid_i,
  input  logic [31:0] exc_target_i,
  input  logic        consume_i,
  output logic        pend_valid_o,
  output logic [31:0] pend_target_o
);

  logic        valid_q, valid_d;
  logic        exc_q, exc_d;
  logic [31:0] target_q, target_d;

  // A pending exception target is never displaced by a later branch.
  always_comb begin
    valid_d  = valid_q;
    exc_d    = exc_q;
    target_d = target_q;
    if (consume_i) begin
      valid_d = 1'b0;
      exc_d   = 1'b0;
    end else if (exc_valid_i) begin
      valid_d  = 1'b1;
      exc_d    = 1'b1;
      target_d = exc_target_i;
    end else if (br_valid_i && !exc_q) begin
      valid_d  = 1'b1;
      target_d = br_target_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      exc_q    <= 1'b0;
      target_q <= NOP;
    end else begin
      valid_q  <= valid_d;
      exc_q    <= exc_d;
      target_q <= target_d;
    end
  end

  assign pend_valid_o  = valid_q;
  assign pend_target_o = target_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, runs the instruction-memory handshake and applies redirects.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallF,
  input  logic        br_redirect,
  input  logic [31:0] br_target,
  input  logic        exc_redirect,
  input  logic [31:0] exc_pc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] pcF,
  output logic [31:0] instrF,
  output logic [31:0] pcplus4F,
  output logic        adelF,
  output logic        inst_stall
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ir_q, ir_d;
  logic         pc_upd;
  logic         redirect, kill;
  logic         pend_valid;
  logic [31:0]  pend_target;

  assign redirect = br_redirect | exc_redirect;
  assign kill     = redirect | pend_valid;

  fetch_redirect_buf u_redirect_buf (
    .clk_i         (clk),
    .rst_i         (reset),
    .br_valid_i    (br_redirect),
    .br_target_i   (br_target),
    .exc_valid_i   (exc_redirect),
    .exc_target_i  (exc_pc),
    .consume_i     (pc_upd),
    .pend_valid_o  (pend_valid),
    .pend_target_o (pend_target)
  );

  assign pcF      = pc_q;
  assign pcplus4F = pc_q + 32'd4;
  assign adelF    = |pc_q[1:0];

  // A redirect seen while an access is outstanding cannot cancel it; the
  // access is drained in S_DISCARD and the target waits in the redirect buffer.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_upd  = 1'b0;
    case (state_q)
      S_REQ: begin
        if (adelF) begin
          pc_upd = !stallF || kill;
        end else if (inst_addr_ok) begin
          state_d = kill ? S_DISCARD : S_WAIT;
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          if (!stallF || kill) begin
            pc_upd  = 1'b1;
            state_d = S_REQ;
          end else begin
            ir_d    = inst_rdata;
            state_d = S_HOLD;
          end
        end else if (kill) begin
          state_d = S_DISCARD;
        end
      end
      S_HOLD: begin
        if (!stallF || kill) begin
          pc_upd  = 1'b1;
          state_d = S_REQ;
        end
      end
      S_DISCARD: begin
        if (inst_data_ok) begin
          pc_upd  = 1'b1;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (pc_upd) begin
      if (exc_redirect)     pc_d = exc_pc;
      else if (br_redirect) pc_d = br_target;
      else if (pend_valid)  pc_d = pend_target;
      else                  pc_d = pcplus4F;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      ir_q    <= NOP;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  assign inst_req   = (state_q == S_REQ) && !adelF;
  assign inst_addr  = {pc_q[31:2], 2'b00};
  assign inst_stall = !((state_q == S_HOLD) ||
                        (state_q == S_WAIT && inst_data_ok) || adelF);

  always_comb begin
    instrF = NOP;
    if (!adelF) begin
      if (state_q == S_WAIT && inst_data_ok) instrF = inst_rdata;
      else if (state_q == S_HOLD)            instrF = ir_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model, vector table, scoreboard of fetched words.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallF;
  logic        br_redirect, exc_redirect;
  logic [31:0] br_target, exc_pc;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic [31:0] pcF, instrF, pcplus4F;
  logic        adelF, inst_stall;

  fetch_unit #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk          (clk),
    .reset        (rst),
    .stallF       (stallF),
    .br_redirect  (br_redirect),
    .br_target    (br_target),
    .exc_redirect (exc_redirect),
    .exc_pc       (exc_pc),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .pcF          (pcF),
    .instrF       (instrF),
    .pcplus4F     (pcplus4F),
    .adelF        (adelF),
    .inst_stall   (inst_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic [31:0] target;
    int unsigned alat;
    int unsigned dlat;
    int unsigned hold;
    int unsigned n;
    logic        exp_req;
    logic        exp_stall;
    logic [31:0] exp_instr;
    int          exp_cycles;
  } vec_t;

  exp_t        sb[$];
  logic [31:0] acc_q[$];
  int          checks = 0;
  int          errors = 0;

  int unsigned addr_lat = 0, data_lat = 0;
  int unsigned acc_cnt = 0, resp_cnt = 0;
  bit          resp_pend = 1'b0;
  logic [31:0] resp_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for the DUT (t=%0t)", name, $time);
  endtask

  task automatic check_outs(input string name, input logic [31:0] pc, input logic req,
                            input logic stall, input logic [31:0] instr);
    chk({name, ".pcF"},       pcF,              pc);
    chk({name, ".pcplus4F"},  pcplus4F,         pc + 32'd4);
    chk({name, ".adelF"},     32'(adelF),       32'(|pc[1:0]));
    chk({name, ".inst_addr"}, inst_addr,        {pc[31:2], 2'b00});
    chk({name, ".inst_req"},  32'(inst_req),    32'(req));
    chk({name, ".inst_stall"},32'(inst_stall),  32'(stall));
    chk({name, ".instrF"},    instrF,           instr);
  endtask

  task automatic push_stream(input logic [31:0] start, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      logic [31:0] a;
      a = start + 32'(4 * i);
      sb.push_back('{a, (|a[1:0]) ? 32'h0 : mem_word(a)});
    end
  endtask

  task automatic prewait(input string name);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      #1;
      if (!inst_stall) return;
    end
    timeout_fail(name);
  endtask

  task automatic drain(input string name, output int cyc);
    cyc = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      cyc++;
      if (sb.size() == 0) begin
        stallF = 1'b1;
        return;
      end
    end
    stallF = 1'b1;
    timeout_fail(name);
    sb.delete();
  endtask

  // Instruction memory: addr_ok after addr_lat waiting cycles, data_ok data_lat cycles later.
  initial begin
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      inst_rdata   = 32'hDEAD_BEEF;
      if (rst) begin
        acc_cnt   = 0;
        resp_pend = 1'b0;
      end else if (resp_pend) begin
        if (resp_cnt == 0) begin
          inst_data_ok = 1'b1;
          inst_rdata   = mem_word(resp_addr);
          resp_pend    = 1'b0;
        end else begin
          resp_cnt--;
        end
      end else if (inst_req) begin
        if (acc_cnt < addr_lat) begin
          acc_cnt++;
        end else begin
          inst_addr_ok = 1'b1;
          resp_pend    = 1'b1;
          resp_addr    = inst_addr;
          resp_cnt     = data_lat;
          acc_cnt      = 0;
          acc_q.push_back(inst_addr);
        end
      end
    end
  end

  // Scoreboard: every instruction the decode stage accepts must match the next expected word.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst && !stallF && !inst_stall && !br_redirect && !exc_redirect) begin
        if (sb.size() == 0) begin
          timeout_fail("sb.unexpected_fetch");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb.pcF",     pcF,      e.pc);
          chk("sb.instrF",  instrF,   e.instr);
          chk("sb.pcplus4", pcplus4F, e.pc + 32'd4);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    int   cyc;

    vecs[0] = '{32'hBFC0_0000, 0, 0, 6, 3, 1'b0, 1'b0, mem_word(32'hBFC0_0000), 5};
    vecs[1] = '{32'h8000_0100, 2, 1, 3, 2, 1'b1, 1'b1, 32'h0, -1};
    vecs[2] = '{32'h8000_0002, 0, 0, 2, 2, 1'b0, 1'b0, 32'h0, -1};
    vecs[3] = '{32'hFFFF_FFF8, 0, 1, 1, 3, 1'b1, 1'b1, 32'h0, -1};
    vecs[4] = '{32'h0000_1000, 1, 0, 4, 2, 1'b0, 1'b0, mem_word(32'h0000_1000), -1};

    rst = 1'b1;
    stallF = 1'b1;
    br_redirect = 1'b0;
    exc_redirect = 1'b0;
    br_target = '0;
    exc_pc = '0;
    repeat (2) @(negedge clk);
    #1 check_outs("reset", 32'hBFC0_0000, 1'b1, 1'b1, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int unsigned i = 0; i < 5; i++) begin
      prewait("vec.prewait");
      addr_lat = vecs[i].alat;
      data_lat = vecs[i].dlat;
      acc_q.delete();
      push_stream(vecs[i].target, vecs[i].n);
      @(negedge clk);
      exc_redirect = 1'b1;
      exc_pc = vecs[i].target;
      @(negedge clk);
      exc_redirect = 1'b0;
      repeat (vecs[i].hold - 1) @(negedge clk);
      #1 check_outs($sformatf("vec%0d", i), vecs[i].target, vecs[i].exp_req,
                    vecs[i].exp_stall, vecs[i].exp_instr);
      @(negedge clk);
      stallF = 1'b0;
      drain("vec.drain", cyc);
      if (vecs[i].exp_cycles >= 0) chk($sformatf("vec%0d.cycles", i), 32'(cyc), 32'(vecs[i].exp_cycles));
      if (|vecs[i].target[1:0]) begin
        chk($sformatf("vec%0d.no_req", i), 32'(acc_q.size()), 32'h0);
      end else begin
        for (int unsigned j = 0; j < vecs[i].n; j++)
          chk($sformatf("vec%0d.addr%0d", i, j), (acc_q.size() > j) ? acc_q[j] : 32'hXXXX_XXXX,
              vecs[i].target + 32'(4 * j));
      end
    end

    // Branch while an access is in flight: the old word must never reach instrF.
    prewait("brwait.prewait");
    addr_lat = 0;
    data_lat = 3;
    acc_q.delete();
    @(negedge clk); exc_redirect = 1'b1; exc_pc = 32'h0000_2000;
    @(negedge clk); exc_redirect = 1'b0;
    @(negedge clk); br_redirect = 1'b1; br_target = 32'h8000_0100;
    push_stream(32'h8000_0100, 2);
    @(negedge clk); br_redirect = 1'b0; stallF = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 check_outs("brwait.discard", 32'h0000_2000, 1'b0, 1'b1, 32'h0);
    drain("brwait.drain", cyc);
    chk("brwait.addr0", (acc_q.size() > 0) ? acc_q[0] : 32'hXXXX_XXXX, 32'h0000_2000);
    chk("brwait.addr1", (acc_q.size() > 1) ? acc_q[1] : 32'hXXXX_XXXX, 32'h8000_0100);

    // Branch then exception while discarding: exception target wins.
    prewait("brexc.prewait");
    acc_q.delete();
    @(negedge clk); exc_redirect = 1'b1; exc_pc = 32'h0000_2000;
    @(negedge clk); exc_redirect = 1'b0;
    @(negedge clk); br_redirect = 1'b1; br_target = 32'h8000_0100;
    @(negedge clk); br_redirect = 1'b0; exc_redirect = 1'b1; exc_pc = 32'hBFC0_0380;
    push_stream(32'hBFC0_0380, 2);
    @(negedge clk); exc_redirect = 1'b0; stallF = 1'b0;
    #1 check_outs("brexc.discard", 32'h0000_2000, 1'b0, 1'b1, 32'h0);
    drain("brexc.drain", cyc);
    chk("brexc.addr1", (acc_q.size() > 1) ? acc_q[1] : 32'hXXXX_XXXX, 32'hBFC0_0380);

    // Asynchronous reset with an access outstanding, then a clean restart.
    prewait("rst.prewait");
    addr_lat = 2;
    data_lat = 1;
    @(negedge clk); exc_redirect = 1'b1; exc_pc = 32'h0000_3000;
    @(negedge clk); exc_redirect = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_outs("rst.wait", 32'h0000_3000, 1'b0, 1'b1, 32'h0);
    #1 rst = 1'b1;
    #1 check_outs("rst.async", 32'hBFC0_0000, 1'b1, 1'b1, 32'h0);
    @(negedge clk);
    push_stream(32'hBFC0_0000, 2);
    @(negedge clk); rst = 1'b0; stallF = 1'b0;
    drain("rst.drain", cyc);

    chk("sb.empty", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
